dff_pipe_sync: RTL

- Parametrised elastic register pipeline, WIDTH bits wide and DEPTH stages deep.
- Each stage carries its own valid bit. Data moves under a valid/ready handshake, and bubbles collapse when the output stalls.
- Provides a synchronous flush (clear) on top of the asynchronous active-low reset, plus an occupancy count.
- Used as the general-purpose retiming/staging register between datapath blocks, replacing single-bit flop instances.

---
 rtl/dff_pipe_sync.sv | 83 ++++++++
 1 files changed

// File: rtl/dff_pipe_sync.sv
// Elastic register pipeline: DEPTH stages of WIDTH bits with per-stage valid,
// valid/ready handshake, bubble collapse, synchronous flush and occupancy count.
module dff_pipe_sync #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] stage_v;
  logic [DEPTH-1:0] adv;

  // A stage may advance if it is empty or everything downstream of it can move.
  always_comb begin : adv_chain
    logic ripple;
    // NOTE: every bit gets a default before the loop, so no latch can be inferred.
    adv    = '0;
    ripple = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ripple = ~valid_q[i] | ripple;
      adv[i] = ripple;
    end
  end

  always_comb begin
    stage_v[0] = in_valid;
    stage_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      stage_v[i] = valid_q[i-1];
      stage_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      // NOTE: data registers are reset as well, so out_data shows RESET_VAL straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VAL;
      end
    end else if (clear) begin
      valid_q <= '0;
    end else begin
      // NOTE: non-blocking so each stage captures its upstream neighbour's pre-edge value.
      for (int i = 0; i < DEPTH; i++) begin
        if (adv[i]) begin
          valid_q[i] <= stage_v[i];
          // Bubbles leave the data register untouched to avoid needless toggling.
          if (stage_v[i]) begin
            data_q[i] <= stage_d[i];
          end
        end
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(valid_q[i]);
    end
  end

  assign in_ready  = adv[0] & ~clear;
  assign out_valid = valid_q[DEPTH-1] & ~clear;
  assign out_data  = data_q[DEPTH-1];

endmodule
